roi_bit_packer: RTL

Parametrised capture block between the CCD capture/demosaic pipeline and the HPS. For one armed frame it thresholds each valid pixel to one bit, keeps only pixels inside a programmable region of interest, and packs them into WORD_W-bit words. Words are buffered in a FIFO and handed to the HPS through a synchronised four-phase req/ack handshake, replacing single-bit, HPS-clocked pixel reads.

---
 rtl/roi_pkg.sv | 24 ++
 rtl/bin_word_fifo.sv | 48 ++++
 rtl/roi_bit_packer.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/roi_pkg.sv
// Shared types and sizing helpers for the ROI bit packer and its word FIFO.
package roi_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_FLUSH   = 3'd3,
    ST_DRAIN   = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  // PTR_W = $clog2(FIFO_DEPTH), BITPOS_W = $clog2(WORD_W); never below 1 bit
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int bitpos_w(input int word_w);
    return (word_w > 1) ? $clog2(word_w) : 1;
  endfunction

endpackage

// File: rtl/bin_word_fifo.sv
// Synchronous word FIFO; a push into a full FIFO is accepted only when a pop frees a slot that cycle.
module bin_word_fifo
  import roi_pkg::*;
#(
  parameter int W     = 32,
  parameter int DEPTH = 16
) (
  input  logic         iCLK,
  input  logic         iRST_N,
  input  logic         i_push,
  input  logic [W-1:0] i_wdata,
  input  logic         i_pop,
  output logic [W-1:0] o_rdata,
  output logic         o_full,
  output logic         o_empty
);

  localparam int PTR_W = ptr_w(DEPTH);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr, r_rptr;
  logic [PTR_W:0]   r_cnt;
  logic             w_wr, w_rd;

  assign o_full  = (r_cnt == (PTR_W+1)'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign w_rd    = i_pop && !o_empty;
  assign w_wr    = i_push && (!o_full || w_rd);
  assign o_rdata = r_mem[r_rptr];

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
      if (w_wr && !w_rd)      r_cnt <= r_cnt + 1'b1;
      else if (w_rd && !w_wr) r_cnt <= r_cnt - 1'b1;
    end
  end

  always_ff @(posedge iCLK) begin
    if (w_wr) r_mem[r_wptr] <= i_wdata;
  end

endmodule

// File: rtl/roi_bit_packer.sv
// Thresholds ROI pixels of one armed frame to bits, packs them into words and
// hands the words to the HPS over a synchronised four-phase req/ack handshake.
module roi_bit_packer
  import roi_pkg::*;
#(
  parameter int PIX_W      = 12,
  parameter int WORD_W     = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int COORD_W    = 12
) (
  input  logic               iCLK,
  input  logic               iRST_N,
  input  logic [PIX_W-1:0]   iDATA,
  input  logic               iDVAL,
  input  logic               iFVAL,
  input  logic               iLVAL,
  input  logic [PIX_W-1:0]   iTHRESHOLD,
  input  logic               iINVERT,
  input  logic [COORD_W-1:0] iX0,
  input  logic [COORD_W-1:0] iX1,
  input  logic [COORD_W-1:0] iY0,
  input  logic [COORD_W-1:0] iY1,
  input  logic               iSTART,
  input  logic               iRD_REQ,
  output logic [WORD_W-1:0]  oRD_DATA,
  output logic               oRD_ACK,
  output logic               oDONE,
  output logic               oOVF,
  output logic [15:0]        oWORD_CNT,
  output logic [STATE_W-1:0] oSTATE
);

  localparam int BITPOS_W = bitpos_w(WORD_W);

  state_e               r_state, w_state_nxt;
  logic                 r_fval_d, r_lval_d;
  logic [COORD_W-1:0]   r_x, r_y, r_x0, r_x1, r_y0, r_y1;
  logic [PIX_W-1:0]     r_thr;
  logic                 r_inv;
  logic                 r_pix_vld, r_pix_bit;
  logic [BITPOS_W-1:0]  r_pos;
  logic [WORD_W-1:0]    r_word, r_rd_data;
  logic                 r_req_m, r_req_s, r_ack, r_ovf;
  logic [15:0]          r_wcnt;

  logic w_fval_rise, w_fval_fall, w_lval_fall, w_in_roi, w_keep;
  logic w_last, w_flush, w_push, w_pop, w_full, w_empty;
  logic [WORD_W-1:0] w_word_nxt, w_push_data, w_head;

  assign w_fval_rise = iFVAL && !r_fval_d;
  assign w_fval_fall = !iFVAL && r_fval_d;
  assign w_lval_fall = !iLVAL && r_lval_d;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: if (iSTART)                w_state_nxt = ST_ARMED;
      ST_ARMED:         if (w_fval_rise)           w_state_nxt = ST_CAPTURE;
      ST_CAPTURE:       if (w_fval_fall)           w_state_nxt = ST_FLUSH;
      ST_FLUSH:                                    w_state_nxt = ST_DRAIN;
      ST_DRAIN:         if (w_empty && !r_ack)     w_state_nxt = ST_DONE;
      default:                                     w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state  <= ST_IDLE;
      r_fval_d <= 1'b0;
      r_lval_d <= 1'b0;
      r_x      <= '0;
      r_y      <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_fval_d <= iFVAL;
      r_lval_d <= iLVAL;
      if (w_fval_rise) begin
        r_x <= '0;
        r_y <= '0;
      end else if (w_lval_fall) begin
        r_x <= '0;
        r_y <= r_y + 1'b1;
      end else if (iDVAL) begin
        r_x <= r_x + 1'b1;
      end
    end
  end

  // Gating on iFVAL keeps the pixel stage empty during FLUSH, so flush and word-complete never collide
  assign w_in_roi = (r_x >= r_x0) && (r_x <= r_x1) && (r_y >= r_y0) && (r_y <= r_y1);
  assign w_keep   = (r_state == ST_CAPTURE) && iFVAL && iDVAL && w_in_roi;

  assign w_word_nxt  = r_word | (WORD_W'(r_pix_bit) << r_pos);
  assign w_last      = r_pix_vld && (r_pos == BITPOS_W'(WORD_W-1));
  assign w_flush     = (r_state == ST_FLUSH) && (r_pos != '0);
  assign w_push      = w_last || w_flush;
  assign w_push_data = w_last ? w_word_nxt : r_word;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_x0 <= '0; r_x1 <= '0; r_y0 <= '0; r_y1 <= '0;
      r_thr     <= '0;
      r_inv     <= 1'b0;
      r_pix_vld <= 1'b0;
      r_pix_bit <= 1'b0;
      r_pos     <= '0;
      r_word    <= '0;
      r_ovf     <= 1'b0;
      r_wcnt    <= '0;
    end else begin
      r_pix_vld <= w_keep;
      r_pix_bit <= (iDATA > r_thr) ^ r_inv;
      if (r_state == ST_ARMED) begin
        r_x0 <= iX0; r_x1 <= iX1; r_y0 <= iY0; r_y1 <= iY1;
        r_thr  <= iTHRESHOLD;
        r_inv  <= iINVERT;
        r_pos  <= '0;
        r_word <= '0;
        r_ovf  <= 1'b0;
        r_wcnt <= '0;
      end else begin
        if (w_push) begin
          r_pos  <= '0;
          r_word <= '0;
          r_wcnt <= r_wcnt + 16'd1;
        end else if (r_pix_vld) begin
          r_pos  <= r_pos + 1'b1;
          r_word <= w_word_nxt;
        end
        if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
      end
    end
  end

  bin_word_fifo #(.W(WORD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .iCLK    (iCLK),
    .iRST_N  (iRST_N),
    .i_push  (w_push),
    .i_wdata (w_push_data),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_pop = (r_state != ST_IDLE) && r_req_s && !r_ack && !w_empty;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_req_m   <= 1'b0;
      r_req_s   <= 1'b0;
      r_ack     <= 1'b0;
      r_rd_data <= '0;
    end else begin
      r_req_m <= iRD_REQ;
      r_req_s <= r_req_m;
      if (w_pop) begin
        r_rd_data <= w_head;
        r_ack     <= 1'b1;
      end else if ((r_state != ST_IDLE) && !r_req_s && r_ack) begin
        r_ack <= 1'b0;
      end
    end
  end

  assign oRD_DATA  = r_rd_data;
  assign oRD_ACK   = r_ack;
  assign oDONE     = (r_state == ST_DONE);
  assign oOVF      = r_ovf;
  assign oWORD_CNT = r_wcnt;
  assign oSTATE    = r_state;

endmodule
